reg_file_2r1w: RTL and testbench
================================

// Module: reg_file_2r1w
// PURPOSE
// 16-bit processor register file: one write port, two read ports (A, B).
// Sits directly downstream of the RF write-data mux (RAM read data vs ALU result).
// Its A/B read data feed the ALU operands.
// Also provides a hardware clear-all sweep driven by a small FSM, with busy and error status.
// PARAMETERS
// DATA_W  16  width of each register and of all data ports
// ADDR_W  4   register address width; DEPTH = 2**ADDR_W entries (16)
// PORTS
// Clk      in   1       system clock, all state updates on rising edge
// Rst_n    in   1       asynchronous reset, active-low
// W_data   in   DATA_W  write data (from RF write-data mux)
// W_addr   in   ADDR_W  write address
// W_en     in   1       write enable
// Ra_addr  in   ADDR_W  read port A address
// Rb_addr  in   ADDR_W  read port B address
// Clr      in   1       start clear-all sweep (sampled in IDLE only)
// Ra_data  out  DATA_W  read port A data, registered
// Rb_data  out  DATA_W  read port B data, registered
// Busy     out  1       high while the clear sweep is in progress
// Wr_err   out  1       sticky: a write was dropped because Busy was high
// BEHAVIOUR
// Reset (Rst_n=0, async, immediate), held until Rst_n rises:
//  - all DEPTH entries = 0; Ra_data = Rb_data = 0
//  - Busy = 0; Wr_err = 0; state = IDLE; sweep pointer ptr = 0
// FSM states: IDLE, CLEAR. Busy = (state == CLEAR), registered.
// IDLE:
//  - W_en=1: mem[W_addr] <= W_data at the edge
//  - Clr=1: state -> CLEAR, ptr <= 0
//  - W_en and Clr in the same cycle: the write is performed, then swept to 0 later
// CLEAR:
//  - each cycle: mem[ptr] <= 0; ptr <= ptr + 1
//  - at ptr == DEPTH-1: final write, state -> IDLE, ptr wraps to 0
//  - Busy is high for exactly DEPTH cycles
//  - Clr in CLEAR is ignored; the sweep is not restarted
//  - W_en=1 in CLEAR: write dropped (not queued); Wr_err <= 1
//  - Wr_err is cleared only by reset
// Read ports (every cycle, both states, 1-cycle latency):
//  - Ra_data <= bypass ? W_data : mem[Ra_addr]; same rule for port B with Rb_addr
//  - bypass (write-first) when state==IDLE, W_en=1, and W_addr equals the read address
//  - in CLEAR, a read address equal to ptr returns 0 (sweep write-first)
//  - both ports may read the same address, including the one being written
//  - register 0 is an ordinary writable register (not hardwired to zero)
// Width rules:
//  - no arithmetic on data
//  - ptr is ADDR_W bits and wraps naturally
// Mid-operation reset:
//  - reset during CLEAR aborts the sweep
//  - all entries are 0 after reset regardless of sweep progress
// TESTING
// 1 Reset: Rst_n=0 mid-cycle -> Ra_data=Rb_data=0, Busy=0, Wr_err=0 immediately;
//   then read all 16 addresses -> all 0x0000.
// 2 Write/read: write 0xAAAA@3, 0x5555@7; next cycle Ra_addr=3, Rb_addr=7
//   -> one cycle later Ra_data=0xAAAA, Rb_data=0x5555.
// 3 Bypass: W_en=1, W_addr=5, W_data=0xFFFF, Ra_addr=Rb_addr=5 in the same cycle
//   -> next edge Ra_data=Rb_data=0xFFFF (not the old value).
// 4 Clear sweep: fill all regs with 0x1234, pulse Clr -> Busy high 16 cycles;
//   Clr re-asserted mid-sweep has no effect; afterwards all regs read 0x0000.
// 5 Write during Busy: W_en=1, W_addr=2, W_data=0xBEEF while Busy -> Wr_err=1 (sticky);
//   reg 2 reads 0x0000 after sweep.
// 6 Reset mid-sweep: Rst_n=0 at sweep cycle 6 -> Busy=0 at once;
//   after release all regs 0, new writes accepted, Wr_err=0.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 16-entry register file with one write port, two registered
// read ports (A/B) and a hardware clear-all sweep with busy / dropped-write status.
module reg_file_2r1w #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] W_data,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] Ra_addr,
    input  logic [ADDR_W-1:0] Rb_addr,
    input  logic              Clr,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic              Busy,
    output logic              Wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ra_sel_p0, rb_sel_p0;

    // Busy is a direct decode of the state register, so it is glitch-free and
    // rises the cycle after Clr is accepted.
    assign Busy = (state == CLEAR);

    // Control state register: sweep FSM state and sweep pointer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic: Clr starts a sweep from IDLE only; the sweep visits
    // every entry once and returns to IDLE after the last one (ptr wraps to 0).
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (Clr) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == LAST_PTR) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Storage: the sweep owns the array while active, so user writes are
    // only honoured in IDLE (a write coinciding with Clr lands, then gets swept).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (W_en) begin
            mem[W_addr] <= W_data;
        end
    end

    // Sticky flag for writes dropped because a sweep was running.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Wr_err <= 1'b0;
        end else if ((state == CLEAR) && W_en) begin
            Wr_err <= 1'b1;
        end
    end

    // Read select, write-first: an address being written this cycle returns
    // the incoming value (user data in IDLE, zero for the sweep entry in CLEAR).
    always_comb begin
        ra_sel_p0 = mem[Ra_addr];
        rb_sel_p0 = mem[Rb_addr];
        if (state == CLEAR) begin
            if (Ra_addr == ptr) ra_sel_p0 = '0;
            if (Rb_addr == ptr) rb_sel_p0 = '0;
        end else if (W_en) begin
            if (Ra_addr == W_addr) ra_sel_p0 = W_data;
            if (Rb_addr == W_addr) rb_sel_p0 = W_data;
        end
    end

    // Registered read outputs (one-cycle latency on both ports).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Ra_data <= '0;
            Rb_data <= '0;
        end else begin
            Ra_data <= ra_sel_p0;
            Rb_data <= rb_sel_p0;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed testbench for reg_file_2r1w: reset, write/read, bypass,
// clear sweep, write during sweep, and reset in the middle of a sweep.
module tb_reg_file_2r1w;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              Clk;
    logic              Rst_n;
    logic [DATA_W-1:0] W_data;
    logic [ADDR_W-1:0] W_addr;
    logic              W_en;
    logic [ADDR_W-1:0] Ra_addr;
    logic [ADDR_W-1:0] Rb_addr;
    logic              Clr;
    logic [DATA_W-1:0] Ra_data;
    logic [DATA_W-1:0] Rb_data;
    logic              Busy;
    logic              Wr_err;

    int checks = 0;
    int errors = 0;

    reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .W_data  (W_data),
        .W_addr  (W_addr),
        .W_en    (W_en),
        .Ra_addr (Ra_addr),
        .Rb_addr (Rb_addr),
        .Clr     (Clr),
        .Ra_data (Ra_data),
        .Rb_data (Rb_data),
        .Busy    (Busy),
        .Wr_err  (Wr_err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Stimulus helpers: drive one cycle, then return 1 time unit after the edge.
    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        W_en = 1'b1; W_addr = a; W_data = d;
        @(posedge Clk); #1;
        W_en = 1'b0;
    endtask

    task automatic read_regs(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        Ra_addr = a; Rb_addr = b;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0; W_en = 1'b0; W_addr = '0; W_data = '0;
        Ra_addr = '0; Rb_addr = '0; Clr = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        // put non-zero data on the outputs so the reset has something to clear
        Ra_addr = 4'd4; Rb_addr = 4'd4;
        write_reg(4'd4, 16'h1111);
        checks++;
        if (Ra_data !== 16'h1111) begin
            errors++; $display("FAIL pre_reset_ra: got %h expected %h", Ra_data, 16'h1111);
        end
        #3 Rst_n = 1'b0;
        #1;
        checks++;
        if (Ra_data !== 16'h0000 || Rb_data !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0000/0000", Ra_data, Rb_data);
        end
        checks++;
        if (Busy !== 1'b0 || Wr_err !== 1'b0) begin
            errors++; $display("FAIL reset_status: got busy=%b wr_err=%b expected 0/0", Busy, Wr_err);
        end
        @(posedge Clk); #1 Rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            read_regs(ADDR_W'(i), ADDR_W'(15 - i));
            checks++;
            if (Ra_data !== 16'h0000 || Rb_data !== 16'h0000) begin
                errors++;
                $display("FAIL reset_mem[%0d]: got %h/%h expected 0000/0000", i, Ra_data, Rb_data);
            end
        end
    endtask

    task automatic test_write_read;
        Ra_addr = 4'd0; Rb_addr = 4'd1;
        write_reg(4'd3, 16'hAAAA);
        write_reg(4'd7, 16'h5555);
        write_reg(4'd0, 16'h0F0F);
        read_regs(4'd3, 4'd7);
        checks++;
        if (Ra_data !== 16'hAAAA || Rb_data !== 16'h5555) begin
            errors++; $display("FAIL write_read: got %h/%h expected aaaa/5555", Ra_data, Rb_data);
        end
        read_regs(4'd0, 4'd3);
        checks++;
        if (Ra_data !== 16'h0F0F || Rb_data !== 16'hAAAA) begin
            errors++; $display("FAIL write_read_r0: got %h/%h expected 0f0f/aaaa", Ra_data, Rb_data);
        end
    endtask

    task automatic test_bypass;
        Ra_addr = 4'd0; Rb_addr = 4'd0;
        write_reg(4'd5, 16'h1357);
        Ra_addr = 4'd5; Rb_addr = 4'd5;
        write_reg(4'd5, 16'hFFFF);
        checks++;
        if (Ra_data !== 16'hFFFF || Rb_data !== 16'hFFFF) begin
            errors++; $display("FAIL bypass_same: got %h/%h expected ffff/ffff", Ra_data, Rb_data);
        end
        Ra_addr = 4'd5; Rb_addr = 4'd6;
        write_reg(4'd6, 16'h6666);
        checks++;
        if (Ra_data !== 16'hFFFF || Rb_data !== 16'h6666) begin
            errors++; $display("FAIL bypass_split: got %h/%h expected ffff/6666", Ra_data, Rb_data);
        end
    endtask

    task automatic test_clear_sweep;
        int cnt;
        for (int i = 0; i < 16; i++) write_reg(ADDR_W'(i), 16'h1234);
        read_regs(4'd9, 4'd12);
        checks++;
        if (Ra_data !== 16'h1234 || Rb_data !== 16'h1234) begin
            errors++; $display("FAIL fill: got %h/%h expected 1234/1234", Ra_data, Rb_data);
        end
        Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 3) begin
                Ra_addr = 4'd2;   // the entry being swept next edge
                Rb_addr = 4'd15;  // not yet swept
            end
            if (cnt == 4) begin
                checks++;
                if (Ra_data !== 16'h0000 || Rb_data !== 16'h1234) begin
                    errors++;
                    $display("FAIL sweep_read: got %h/%h expected 0000/1234", Ra_data, Rb_data);
                end
            end
            Clr = (cnt == 6);
            @(posedge Clk); #1;
        end
        Clr = 1'b0;
        checks++;
        if (cnt != 16) begin
            errors++; $display("FAIL busy_cycles: got %0d expected 16", cnt);
        end
        read_regs(4'd0, 4'd1);
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL no_restart: got busy=%b expected 0", Busy);
        end
        for (int i = 0; i < 16; i++) begin
            read_regs(ADDR_W'(i), ADDR_W'(i));
            checks++;
            if (Ra_data !== 16'h0000 || Rb_data !== 16'h0000) begin
                errors++;
                $display("FAIL cleared[%0d]: got %h/%h expected 0000/0000", i, Ra_data, Rb_data);
            end
        end
    endtask

    task automatic test_write_during_busy;
        int cnt;
        checks++;
        if (Wr_err !== 1'b0) begin
            errors++; $display("FAIL wr_err_idle: got %b expected 0", Wr_err);
        end
        Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        // sweep pointer is past entry 2 now, so a leaked write would survive
        write_reg(4'd2, 16'hBEEF);
        checks++;
        if (Wr_err !== 1'b1) begin
            errors++; $display("FAIL wr_err_set: got %b expected 1", Wr_err);
        end
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge Clk); #1;
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL sweep_end: got busy=%b expected 0", Busy);
        end
        read_regs(4'd2, 4'd2);
        checks++;
        if (Ra_data !== 16'h0000) begin
            errors++; $display("FAIL dropped_write: got %h expected 0000", Ra_data);
        end
        Ra_addr = 4'd9; Rb_addr = 4'd2;
        write_reg(4'd9, 16'h9999);
        read_regs(4'd9, 4'd2);
        checks++;
        if (Ra_data !== 16'h9999 || Wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_sticky: got %h wr_err=%b expected 9999 wr_err=1", Ra_data, Wr_err);
        end
    endtask

    task automatic test_reset_mid_sweep;
        write_reg(4'd10, 16'hCAFE);
        Ra_addr = 4'd10; Rb_addr = 4'd10;
        Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        checks++;
        if (Busy !== 1'b1 || Ra_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL mid_sweep: got busy=%b ra=%h expected busy=1 ra=cafe", Busy, Ra_data);
        end
        #3 Rst_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || Wr_err !== 1'b0 || Ra_data !== 16'h0000) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b wr_err=%b ra=%h expected 0/0/0000",
                     Busy, Wr_err, Ra_data);
        end
        @(posedge Clk); #1 Rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            read_regs(ADDR_W'(i), ADDR_W'(i));
            checks++;
            if (Ra_data !== 16'h0000 || Rb_data !== 16'h0000) begin
                errors++;
                $display("FAIL post_abort[%0d]: got %h/%h expected 0000/0000", i, Ra_data, Rb_data);
            end
        end
        Ra_addr = 4'd0; Rb_addr = 4'd0;
        write_reg(4'd10, 16'h4321);
        read_regs(4'd10, 4'd10);
        checks++;
        if (Ra_data !== 16'h4321 || Rb_data !== 16'h4321 || Busy !== 1'b0 || Wr_err !== 1'b0) begin
            errors++;
            $display("FAIL post_abort_write: got %h/%h busy=%b wr_err=%b expected 4321/4321 0 0",
                     Ra_data, Rb_data, Busy, Wr_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_sweep();
        test_write_during_busy();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
